// File: rtl/demultiplexador8b_buf_if.sv
// Byte-stream interface for the buffered 1-to-2 demultiplexer.
// The master is the byte source plus both consumers; the slave is the demultiplexer.
interface demultiplexador8b_buf_if #(
    parameter int W = 8
);
    logic [W-1:0] d;
    logic         p;
    logic         d_v;
    logic         d_rdy;
    logic [W-1:0] a;
    logic         a_v;
    logic         a_rdy;
    logic [W-1:0] b;
    logic         b_v;
    logic         b_rdy;
    logic [7:0]   cnt_a;
    logic [7:0]   cnt_b;

    modport master (
        output d, p, d_v, a_rdy, b_rdy,
        input  d_rdy, a, a_v, b, b_v, cnt_a, cnt_b
    );

    modport slave (
        input  d, p, d_v, a_rdy, b_rdy,
        output d_rdy, a, a_v, b, b_v, cnt_a, cnt_b
    );
endinterface

// File: rtl/demultiplexador8b_buf.sv
// Buffered 1-to-2 byte demultiplexer: routes each accepted byte by p into FIFO A or B,
// each FIFO drained through its own valid/ready port with a mod-256 delivery counter.
module demultiplexador8b_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input logic                       clk,
    input logic                       rst,
    demultiplexador8b_buf_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem_a [DEPTH];
    logic [W-1:0] r_mem_b [DEPTH];
    logic [AW:0]  r_wp_a;
    logic [AW:0]  r_rp_a;
    logic [AW:0]  r_wp_b;
    logic [AW:0]  r_rp_b;
    logic [7:0]   r_cnt_a;
    logic [7:0]   r_cnt_b;

    logic w_empty_a;
    logic w_empty_b;
    logic w_full_a;
    logic w_full_b;
    logic w_rdy;
    logic w_push_a;
    logic w_push_b;
    logic w_pop_a;
    logic w_pop_b;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign w_empty_a = (r_wp_a == r_rp_a);
    assign w_empty_b = (r_wp_b == r_rp_b);
    assign w_full_a  = (r_wp_a[AW] != r_rp_a[AW]) && (r_wp_a[AW-1:0] == r_rp_a[AW-1:0]);
    assign w_full_b  = (r_wp_b[AW] != r_rp_b[AW]) && (r_wp_b[AW-1:0] == r_rp_b[AW-1:0]);

    assign w_rdy    = bus.p ? ~w_full_b : ~w_full_a;
    assign w_push_a = bus.d_v & w_rdy & ~bus.p;
    assign w_push_b = bus.d_v & w_rdy &  bus.p;
    assign w_pop_a  = ~w_empty_a & bus.a_rdy;
    assign w_pop_b  = ~w_empty_b & bus.b_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp_a  <= '0;
            r_rp_a  <= '0;
            r_wp_b  <= '0;
            r_rp_b  <= '0;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (w_push_a) r_wp_a <= r_wp_a + 1'b1;
            if (w_push_b) r_wp_b <= r_wp_b + 1'b1;
            if (w_pop_a) begin
                r_rp_a  <= r_rp_a + 1'b1;
                r_cnt_a <= r_cnt_a + 8'd1;
            end
            if (w_pop_b) begin
                r_rp_b  <= r_rp_b + 1'b1;
                r_cnt_b <= r_cnt_b + 8'd1;
            end
        end
    end

    // Storage needs no reset: pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (!rst && w_push_a) r_mem_a[r_wp_a[AW-1:0]] <= bus.d;
        if (!rst && w_push_b) r_mem_b[r_wp_b[AW-1:0]] <= bus.d;
    end

    assign bus.d_rdy = w_rdy;
    assign bus.a_v   = ~w_empty_a;
    assign bus.b_v   = ~w_empty_b;
    assign bus.a     = w_empty_a ? '0 : r_mem_a[r_rp_a[AW-1:0]];
    assign bus.b     = w_empty_b ? '0 : r_mem_b[r_rp_b[AW-1:0]];
    assign bus.cnt_a = r_cnt_a;
    assign bus.cnt_b = r_cnt_b;
endmodule

// File: tb/tb_demultiplexador8b_buf.sv
// Scoreboard bench for demultiplexador8b_buf: per-output expected queues fed on acceptance,
// drained by a monitor on each output pop; directed scenarios followed by random traffic.
module tb_demultiplexador8b_buf;
    localparam int W     = 8;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    demultiplexador8b_buf_if #(.W(W)) bus ();

    demultiplexador8b_buf #(.W(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected contents of each output queue and delivery counts.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         cnt_a_m = 0;
    int         cnt_b_m = 0;
    bit         armed   = 0;
    bit         pend_push_a, pend_push_b, pend_pop_a, pend_pop_b;
    logic [7:0] pend_d;
    bit         last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Stimulus side: decide acceptance from the model's occupancy and queue the byte.
    always @(negedge clk) begin
        bit exp_rdy;
        exp_rdy = bus.p ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
        if (armed) chk("d_rdy", {31'd0, bus.d_rdy}, {31'd0, exp_rdy});
        last_acc    = bus.d_v && exp_rdy && !rst;
        pend_push_a = last_acc && !bus.p;
        pend_push_b = last_acc &&  bus.p;
        pend_d      = bus.d;
    end

    // Monitor: compare output heads and counters, pop on each handshake.
    always @(negedge clk) begin
        pend_pop_a = 0;
        pend_pop_b = 0;
        if (armed) begin
            chk("a_v", {31'd0, bus.a_v}, {31'd0, qa.size() != 0});
            chk("b_v", {31'd0, bus.b_v}, {31'd0, qb.size() != 0});
            chk("cnt_a", {24'd0, bus.cnt_a}, cnt_a_m);
            chk("cnt_b", {24'd0, bus.cnt_b}, cnt_b_m);
            if (qa.size() != 0) begin
                chk("a_data", {24'd0, bus.a}, {24'd0, qa[0]});
                pend_pop_a = bus.a_rdy;
            end
            if (qb.size() != 0) begin
                chk("b_data", {24'd0, bus.b}, {24'd0, qb[0]});
                pend_pop_b = bus.b_rdy;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            cnt_a_m = 0;
            cnt_b_m = 0;
            armed   = 1;
        end else if (armed) begin
            if (pend_pop_a) begin
                void'(qa.pop_front());
                cnt_a_m = (cnt_a_m + 1) % 256;
            end
            if (pend_pop_b) begin
                void'(qb.pop_front());
                cnt_b_m = (cnt_b_m + 1) % 256;
            end
            if (pend_push_a) qa.push_back(pend_d);
            if (pend_push_b) qb.push_back(pend_d);
        end
    end

    task automatic drive(input logic dv, input logic [7:0] dd, input logic pp,
                         input logic ar, input logic br);
        @(posedge clk);
        #1;
        bus.d_v   = dv;
        bus.d     = dd;
        bus.p     = pp;
        bus.a_rdy = ar;
        bus.b_rdy = br;
    endtask

    task automatic idle(input int n, input logic ar, input logic br);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, ar, br);
    endtask

    // Holds the byte until the model says it was accepted; bounded wait.
    task automatic send(input logic [7:0] dd, input logic pp, input logic ar, input logic br);
        int n;
        n = 0;
        drive(1'b1, dd, pp, ar, br);
        forever begin
            @(negedge clk);
            #1;
            if (last_acc) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.d     = '0;
        bus.p     = 1'b0;
        bus.d_v   = 1'b0;
        bus.a_rdy = 1'b0;
        bus.b_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_a", {24'd0, bus.a}, 32'd0);
        chk("reset_b", {24'd0, bus.b}, 32'd0);
        chk("reset_d_rdy", {31'd0, bus.d_rdy}, 32'd1);

        // single byte to A
        send(8'h5A, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b0);

        // B fills, third byte stalls, then drains in order
        send(8'h11, 1'b1, 1'b0, 1'b0);
        send(8'h22, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        send(8'h33, 1'b1, 1'b0, 1'b1);
        idle(4, 1'b0, 1'b1);

        // B full and stalled while A streams
        send(8'hB0, 1'b1, 1'b0, 1'b0);
        send(8'hB1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b1);

        // A full, pop and refused push in the same cycle
        send(8'hC1, 1'b0, 1'b0, 1'b0);
        send(8'hC2, 1'b0, 1'b0, 1'b0);
        send(8'hC3, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1, 1'b0);

        // counter wrap on A
        for (int i = 0; i < 300; i++) send(8'(i), 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1, 1'b1);

        // reset with both FIFOs full
        send(8'hE1, 1'b0, 1'b0, 1'b0);
        send(8'hE2, 1'b0, 1'b0, 1'b0);
        send(8'hF1, 1'b1, 1'b0, 1'b0);
        send(8'hF2, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.d_v = 1'b1;
        bus.d   = 8'hEE;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.d_v   = 1'b0;
        bus.a_rdy = 1'b1;
        bus.b_rdy = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid_a_v", {31'd0, bus.a_v}, 32'd0);
        chk("rst_mid_b_v", {31'd0, bus.b_v}, 32'd0);
        chk("rst_mid_cnt_a", {24'd0, bus.cnt_a}, 32'd0);
        idle(4, 1'b1, 1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            else                             rst = 1'b0;
        end
        rst = 1'b0;
        idle(10, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
